// File: rtl/az_window_decoder.sv
// Decodes auto-zero HI/LO sample windows, accumulates ADC samples per window and publishes
// one HI/LO pair per AZ cycle over valid/ready. Optional wait watchdog: AZ_DECODE_TIMEOUT_EN.
module az_window_decoder #(
    parameter int unsigned TIMEOUT_CLKS = 32'd20000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  azmux_hi_val,
    input  logic [3:0]  azmux_lo_val,
    input  logic        sw_pc_ctl,
    input  logic [3:0]  azmux,
    input  logic        adc_valid,
    input  logic [23:0] adc_data,
    input  logic        result_ready,
    output logic        result_valid,
    output logic [31:0] hi_sum,
    output logic [31:0] lo_sum,
    output logic [31:0] az_diff,
    output logic [31:0] hi_clks,
    output logic [31:0] lo_clks,
    output logic [15:0] n_hi,
    output logic [15:0] n_lo,
    output logic        overrun,
    output logic        timeout,
    output logic        led0,
    output logic [7:0]  monitor
);
    localparam int unsigned DW = 24;
    localparam int unsigned AW = 32;
    localparam int unsigned NW = 16;
    localparam int unsigned CW = 32;

    typedef enum logic [2:0] {SYNC, WAIT_HI, HI_WIN, WAIT_LO, LO_WIN, PUBLISH} state_t;

    state_t        state, state_d;
    logic          hi_cond, lo_cond;
    logic          in_wait, win_start, tmo_hit;
    logic          rv_d, ovr_d, tmo_d;
    logic [AW-1:0] sample_ext;
    logic [AW-1:0] w_hi_sum, w_lo_sum, w_hi_clks, w_lo_clks;
    logic [NW-1:0] w_n_hi, w_n_lo;

    // The two windows differ in sw_pc_ctl, so they never overlap even with equal codes.
    assign hi_cond    = sw_pc_ctl && (azmux == azmux_hi_val);
    assign lo_cond    = !sw_pc_ctl && (azmux == azmux_lo_val);
    assign sample_ext = {{(AW-DW){adc_data[DW-1]}}, adc_data};
    assign in_wait    = (state == WAIT_HI) || (state == WAIT_LO);
    assign win_start  = ((state == WAIT_HI) && hi_cond) || ((state == WAIT_LO) && lo_cond);

`ifdef AZ_DECODE_TIMEOUT_EN
    logic [CW-1:0] tmo_cnt;

    // Wait states are never entered from each other, so clearing outside them covers entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (in_wait && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = in_wait && !win_start && (tmo_cnt == CW'(TIMEOUT_CLKS - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^CW'(TIMEOUT_CLKS);
    assign tmo_hit            = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_d;
        end
    end

    // Next state plus next values of the status flags.
    always_comb begin
        state_d = state;
        rv_d    = result_valid;
        ovr_d   = overrun;
        tmo_d   = timeout | tmo_hit;
        case (state)
            SYNC:    if (!hi_cond) state_d = WAIT_HI;
            WAIT_HI: if (hi_cond) state_d = HI_WIN; else if (tmo_hit) state_d = SYNC;
            HI_WIN:  if (!hi_cond) state_d = WAIT_LO;
            WAIT_LO: if (lo_cond) state_d = LO_WIN; else if (tmo_hit) state_d = SYNC;
            LO_WIN:  if (!lo_cond) state_d = PUBLISH;
            PUBLISH: state_d = WAIT_HI;
            default: state_d = SYNC;
        endcase
        if (state == PUBLISH) begin
            rv_d  = 1'b1;
            ovr_d = overrun | (result_valid && !result_ready);
        end else if (result_valid && result_ready) begin
            rv_d = 1'b0;
        end
    end

    // Working accumulators; each window's entry cycle counts as its first clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_hi_sum  <= '0;
            w_lo_sum  <= '0;
            w_hi_clks <= '0;
            w_lo_clks <= '0;
            w_n_hi    <= '0;
            w_n_lo    <= '0;
        end else if (tmo_hit) begin
            w_hi_sum  <= '0;
            w_lo_sum  <= '0;
            w_hi_clks <= '0;
            w_lo_clks <= '0;
            w_n_hi    <= '0;
            w_n_lo    <= '0;
        end else begin
            case (state)
                WAIT_HI: if (hi_cond) begin
                    w_hi_clks <= AW'(1);
                    w_hi_sum  <= adc_valid ? sample_ext : '0;
                    w_n_hi    <= adc_valid ? NW'(1) : '0;
                    w_lo_clks <= '0;
                    w_lo_sum  <= '0;
                    w_n_lo    <= '0;
                end
                HI_WIN: if (hi_cond) begin
                    w_hi_clks <= w_hi_clks + AW'(1);
                    if (adc_valid) begin
                        w_hi_sum <= w_hi_sum + sample_ext;
                        if (w_n_hi != '1) w_n_hi <= w_n_hi + NW'(1);
                    end
                end
                WAIT_LO: if (lo_cond) begin
                    w_lo_clks <= AW'(1);
                    w_lo_sum  <= adc_valid ? sample_ext : '0;
                    w_n_lo    <= adc_valid ? NW'(1) : '0;
                end
                LO_WIN: if (lo_cond) begin
                    w_lo_clks <= w_lo_clks + AW'(1);
                    if (adc_valid) begin
                        w_lo_sum <= w_lo_sum + sample_ext;
                        if (w_n_lo != '1) w_n_lo <= w_n_lo + NW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_sum       <= '0;
            lo_sum       <= '0;
            az_diff      <= '0;
            hi_clks      <= '0;
            lo_clks      <= '0;
            n_hi         <= '0;
            n_lo         <= '0;
            led0         <= 1'b0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
            monitor      <= '0;
        end else begin
            if (state == PUBLISH) begin
                hi_sum  <= w_hi_sum;
                lo_sum  <= w_lo_sum;
                az_diff <= w_hi_sum - w_lo_sum;
                hi_clks <= w_hi_clks;
                lo_clks <= w_lo_clks;
                n_hi    <= w_n_hi;
                n_lo    <= w_n_lo;
                led0    <= ~led0;
            end
            result_valid <= rv_d;
            overrun      <= ovr_d;
            timeout      <= tmo_d;
            monitor      <= {3'b000, tmo_d, ovr_d, rv_d, (state_d == LO_WIN), (state_d == HI_WIN)};
        end
    end

endmodule
